// File: rtl/forward_history_buffer.sv
// forward_history_buffer
// Shift-register history of the bucket writes issued to the hash-table
// memories. Stage 0 holds the newest write of every table; each enabled edge
// moves the history one stage deeper and drops the oldest stage. The stage
// outputs feed the forward_* inputs of whole_forward_updater.
module forward_history_buffer #(
  parameter int KEY_WIDTH              = 4,
  parameter int DATA_WIDTH             = 8,
  parameter int NUMBER_OF_TABLES       = 3,
  parameter int BUCKET_SIZE            = 2,
  parameter int FORWARDED_CLOCK_CYCLES = 2,
  parameter int MAX_HASH_ADR_WIDTH     = 3,
  localparam int LIVE_W                = $clog2(FORWARDED_CLOCK_CYCLES + 1)
) (
  input  logic                                                                    clk,
  input  logic                                                                    reset,
  input  logic                                                                    clk_en,
  input  logic                                                                    flush_i,
  input  logic [NUMBER_OF_TABLES-1:0]                                             wr_en_i,
  input  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]                     wr_hash_adr_i,
  input  logic [NUMBER_OF_TABLES-1:0][BUCKET_SIZE-1:0]                            wr_slot_i,
  input  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]                              wr_key_i,
  input  logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]                             wr_data_i,
  input  logic [NUMBER_OF_TABLES-1:0]                                             wr_valid_i,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0] forward_hash_adr_o,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]          forward_key_o,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]         forward_data_o,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0][BUCKET_SIZE-1:0]        forward_updated_mem_o,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0][BUCKET_SIZE-1:0]        forward_valid_o,
  output logic [LIVE_W-1:0]                                                               live_stages_o,
  output logic                                                                            slot_error_o
);

  localparam int F = FORWARDED_CLOCK_CYCLES;
  localparam int T = NUMBER_OF_TABLES;
  localparam int B = BUCKET_SIZE;
  localparam int A = MAX_HASH_ADR_WIDTH;

  // History registers; index [k][t] is stage k, table t
  logic [F-1:0][T-1:0][A-1:0]          stage_adr,  stage_adr_nxt;
  logic [F-1:0][T-1:0][KEY_WIDTH-1:0]  stage_key,  stage_key_nxt;
  logic [F-1:0][T-1:0][DATA_WIDTH-1:0] stage_data, stage_data_nxt;
  logic [F-1:0][T-1:0][B-1:0]          stage_upd,  stage_upd_nxt;
  logic [F-1:0][T-1:0][B-1:0]          stage_vld,  stage_vld_nxt;
  logic [LIVE_W-1:0]                   live,       live_nxt;
  logic                                slot_err;
  logic                                bad_slot;

  // True when exactly one bit of the slot vector is set
  function automatic logic one_hot(input logic [B-1:0] s);
    logic [B-1:0] m;
    m = s - B'(1);
    return (s != '0) && ((s & m) == '0);
  endfunction

  // Next history contents: capture into stage 0, shift everything else down,
  // and count the stages that will hold at least one recorded write
  always_comb begin
    stage_adr_nxt  = '0;
    stage_key_nxt  = '0;
    stage_data_nxt = '0;
    stage_upd_nxt  = '0;
    stage_vld_nxt  = '0;
    bad_slot       = 1'b0;
    live_nxt       = '0;

    for (int t = 0; t < T; t++) begin
      if (wr_en_i[t]) begin
        if (one_hot(wr_slot_i[t])) begin
          stage_adr_nxt[0][t]  = wr_hash_adr_i[t];
          stage_key_nxt[0][t]  = wr_key_i[t];
          stage_data_nxt[0][t] = wr_data_i[t];
          stage_upd_nxt[0][t]  = wr_slot_i[t];
          stage_vld_nxt[0][t]  = wr_slot_i[t] & {B{wr_valid_i[t]}};
        end else begin
          // Malformed slot: the write is dropped and the entry stays zero
          bad_slot = 1'b1;
        end
      end
    end

    for (int k = 1; k < F; k++) begin
      stage_adr_nxt[k]  = stage_adr[k-1];
      stage_key_nxt[k]  = stage_key[k-1];
      stage_data_nxt[k] = stage_data[k-1];
      stage_upd_nxt[k]  = stage_upd[k-1];
      stage_vld_nxt[k]  = stage_vld[k-1];
    end

    for (int k = 0; k < F; k++) begin
      if (|stage_upd_nxt[k]) live_nxt = live_nxt + LIVE_W'(1);
    end
  end

  // State update: reset beats everything, a disabled clock freezes all state,
  // flush empties the history but leaves the sticky slot error alone
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_adr  <= '0;
      stage_key  <= '0;
      stage_data <= '0;
      stage_upd  <= '0;
      stage_vld  <= '0;
      live       <= '0;
      slot_err   <= 1'b0;
    end else if (clk_en) begin
      if (flush_i) begin
        stage_adr  <= '0;
        stage_key  <= '0;
        stage_data <= '0;
        stage_upd  <= '0;
        stage_vld  <= '0;
        live       <= '0;
      end else begin
        stage_adr  <= stage_adr_nxt;
        stage_key  <= stage_key_nxt;
        stage_data <= stage_data_nxt;
        stage_upd  <= stage_upd_nxt;
        stage_vld  <= stage_vld_nxt;
        live       <= live_nxt;
        if (bad_slot) slot_err <= 1'b1;
      end
    end
  end

  assign forward_hash_adr_o    = stage_adr;
  assign forward_key_o         = stage_key;
  assign forward_data_o        = stage_data;
  assign forward_updated_mem_o = stage_upd;
  assign forward_valid_o       = stage_vld;
  assign live_stages_o         = live;
  assign slot_error_o          = slot_err;

endmodule

// File: tb/tb_forward_history_buffer.sv
// Directed, table-driven bench for forward_history_buffer at default parameters.
// Each table row is one clock edge: inputs applied before the edge, the full
// expected history checked just after it.
module tb_forward_history_buffer;

  localparam int T  = 3;
  localparam int B  = 2;
  localparam int F  = 2;
  localparam int A  = 3;
  localparam int KW = 4;
  localparam int DW = 8;
  localparam int LW = $clog2(F + 1);
  localparam int NV = 23;

  logic clk = 1'b0;
  logic reset, clk_en, flush_i;
  logic [T-1:0]          wr_en_i;
  logic [T-1:0][A-1:0]   wr_hash_adr_i;
  logic [T-1:0][B-1:0]   wr_slot_i;
  logic [T-1:0][KW-1:0]  wr_key_i;
  logic [T-1:0][DW-1:0]  wr_data_i;
  logic [T-1:0]          wr_valid_i;
  logic [F-1:0][T-1:0][A-1:0]  forward_hash_adr_o;
  logic [F-1:0][T-1:0][KW-1:0] forward_key_o;
  logic [F-1:0][T-1:0][DW-1:0] forward_data_o;
  logic [F-1:0][T-1:0][B-1:0]  forward_updated_mem_o;
  logic [F-1:0][T-1:0][B-1:0]  forward_valid_o;
  logic [LW-1:0]               live_stages_o;
  logic                        slot_error_o;

  forward_history_buffer #(
    .KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUMBER_OF_TABLES(T), .BUCKET_SIZE(B),
    .FORWARDED_CLOCK_CYCLES(F), .MAX_HASH_ADR_WIDTH(A)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wr_hash_adr_i(wr_hash_adr_i), .wr_slot_i(wr_slot_i),
    .wr_key_i(wr_key_i), .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .forward_hash_adr_o(forward_hash_adr_o), .forward_key_o(forward_key_o),
    .forward_data_o(forward_data_o), .forward_updated_mem_o(forward_updated_mem_o),
    .forward_valid_o(forward_valid_o), .live_stages_o(live_stages_o),
    .slot_error_o(slot_error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                       rst_n, en, fl;
    logic [T-1:0]               we;
    logic [T-1:0][A-1:0]        adr;
    logic [T-1:0][B-1:0]        slot;
    logic [T-1:0][KW-1:0]       key;
    logic [T-1:0][DW-1:0]       data;
    logic [T-1:0]               wv;
    logic [F-1:0][T-1:0][A-1:0]  e_adr;
    logic [F-1:0][T-1:0][KW-1:0] e_key;
    logic [F-1:0][T-1:0][DW-1:0] e_data;
    logic [F-1:0][T-1:0][B-1:0]  e_upd;
    logic [F-1:0][T-1:0][B-1:0]  e_vld;
    logic [LW-1:0]              e_live;
    logic                       e_err;
  } vec_t;

  vec_t v[NV];
  int n_checks = 0;
  int n_fail   = 0;

  // Start a row: control inputs plus expected live count and error flag,
  // everything else zero
  task automatic row(input int i, input logic rn, input logic en, input logic fl,
                     input int live, input logic err);
    v[i].rst_n = rn; v[i].en = en; v[i].fl = fl;
    v[i].we = '0; v[i].adr = '0; v[i].slot = '0; v[i].key = '0;
    v[i].data = '0; v[i].wv = '0;
    v[i].e_adr = '0; v[i].e_key = '0; v[i].e_data = '0;
    v[i].e_upd = '0; v[i].e_vld = '0;
    v[i].e_live = live[LW-1:0];
    v[i].e_err  = err;
  endtask

  // Add a write request on table t to row i
  task automatic wr(input int i, input int t, input int adr, input int slot,
                    input int key, input int data, input logic wv);
    v[i].we[t]   = 1'b1;
    v[i].adr[t]  = adr[A-1:0];
    v[i].slot[t] = slot[B-1:0];
    v[i].key[t]  = key[KW-1:0];
    v[i].data[t] = data[DW-1:0];
    v[i].wv[t]   = wv;
  endtask

  // Add an expected entry at stage k, table t of row i
  task automatic ex(input int i, input int k, input int t, input int adr,
                    input int key, input int data, input int upd, input int vld);
    v[i].e_adr[k][t]  = adr[A-1:0];
    v[i].e_key[k][t]  = key[KW-1:0];
    v[i].e_data[k][t] = data[DW-1:0];
    v[i].e_upd[k][t]  = upd[B-1:0];
    v[i].e_vld[k][t]  = vld[B-1:0];
  endtask

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int i);
    check("adr",  i, 64'(forward_hash_adr_o),    64'(v[i].e_adr));
    check("key",  i, 64'(forward_key_o),         64'(v[i].e_key));
    check("data", i, 64'(forward_data_o),        64'(v[i].e_data));
    check("upd",  i, 64'(forward_updated_mem_o), 64'(v[i].e_upd));
    check("vld",  i, 64'(forward_valid_o),       64'(v[i].e_vld));
    check("live", i, 64'(live_stages_o),         64'(v[i].e_live));
    check("err",  i, 64'(slot_error_o),          64'(v[i].e_err));
  endtask

  task automatic drive(input int i);
    reset = v[i].rst_n; clk_en = v[i].en; flush_i = v[i].fl;
    wr_en_i = v[i].we; wr_hash_adr_i = v[i].adr; wr_slot_i = v[i].slot;
    wr_key_i = v[i].key; wr_data_i = v[i].data; wr_valid_i = v[i].wv;
  endtask

  task automatic idle_inputs();
    reset = 1'b1; clk_en = 1'b1; flush_i = 1'b0;
    wr_en_i = '0; wr_hash_adr_i = '0; wr_slot_i = '0;
    wr_key_i = '0; wr_data_i = '0; wr_valid_i = '0;
  endtask

  initial begin
    // Reset and idle
    row(0, 0, 1, 0, 0, 0);
    row(1, 0, 1, 0, 0, 0);
    row(2, 1, 1, 0, 0, 0);
    // Single write walks stage0 -> stage1 -> gone
    row(3, 1, 1, 0, 1, 0); wr(3, 0, 1, 2'b01, 4'h1, 8'h01, 1); ex(3, 0, 0, 1, 4'h1, 8'h01, 2'b01, 2'b01);
    row(4, 1, 1, 0, 1, 0); ex(4, 1, 0, 1, 4'h1, 8'h01, 2'b01, 2'b01);
    row(5, 1, 1, 0, 0, 0);
    // Parallel write with a delete on table 2
    row(6, 1, 1, 0, 1, 0);
    wr(6, 0, 2, 2'b10, 4'h2, 8'h22, 1); wr(6, 2, 5, 2'b10, 4'h5, 8'h55, 0);
    ex(6, 0, 0, 2, 4'h2, 8'h22, 2'b10, 2'b10); ex(6, 0, 2, 5, 4'h5, 8'h55, 2'b10, 2'b00);
    row(7, 1, 1, 0, 2, 0);
    wr(7, 1, 3, 2'b01, 4'h3, 8'h33, 1);
    ex(7, 0, 1, 3, 4'h3, 8'h33, 2'b01, 2'b01);
    ex(7, 1, 0, 2, 4'h2, 8'h22, 2'b10, 2'b10); ex(7, 1, 2, 5, 4'h5, 8'h55, 2'b10, 2'b00);
    // Stall three cycles: writes and flush presented while disabled are ignored
    v[8] = v[7]; v[8].en = 1'b0; v[8].fl = 1'b1;
    v[8].we = '0; wr(8, 0, 7, 2'b01, 4'hF, 8'hFF, 1);
    v[9] = v[7]; v[9].en = 1'b0; v[9].we = '0;
    v[10] = v[9]; wr(10, 2, 6, 2'b11, 4'hE, 8'hEE, 1);
    row(11, 1, 1, 0, 1, 0); ex(11, 1, 1, 3, 4'h3, 8'h33, 2'b01, 2'b01);
    // Two writes, then flush together with a third write
    row(12, 1, 1, 0, 1, 0); wr(12, 0, 4, 2'b01, 4'h4, 8'h44, 1); ex(12, 0, 0, 4, 4'h4, 8'h44, 2'b01, 2'b01);
    row(13, 1, 1, 0, 2, 0); wr(13, 1, 6, 2'b10, 4'h6, 8'h66, 1);
    ex(13, 0, 1, 6, 4'h6, 8'h66, 2'b10, 2'b10); ex(13, 1, 0, 4, 4'h4, 8'h44, 2'b01, 2'b01);
    row(14, 1, 1, 1, 0, 0); wr(14, 2, 7, 2'b01, 4'h7, 8'h77, 1);
    row(15, 1, 1, 0, 0, 0);
    // Multi-hot slot on table 1 alongside a good write on table 0
    row(16, 1, 1, 0, 1, 1);
    wr(16, 1, 1, 2'b11, 4'h9, 8'h99, 1); wr(16, 0, 1, 2'b10, 4'hA, 8'hAA, 1);
    ex(16, 0, 0, 1, 4'hA, 8'hAA, 2'b10, 2'b10);
    row(17, 1, 1, 1, 0, 1);
    row(18, 1, 1, 0, 0, 1); wr(18, 1, 2, 2'b00, 4'h8, 8'h88, 1);
    row(19, 0, 1, 0, 0, 0);
    // Reset mid-history wins over a disabled clock
    row(20, 1, 1, 0, 1, 0); wr(20, 0, 1, 2'b01, 4'h1, 8'h11, 1); ex(20, 0, 0, 1, 4'h1, 8'h11, 2'b01, 2'b01);
    row(21, 0, 0, 0, 0, 0); wr(21, 2, 3, 2'b01, 4'h3, 8'h31, 1);
    row(22, 1, 1, 0, 0, 0);

    drive(0);
    for (int i = 0; i < NV; i++) begin
      drive(i);
      @(posedge clk);
      #1;
      check_all(i);
    end

    // Outputs are registered: changing inputs between edges must not move them
    idle_inputs();
    wr_en_i[2] = 1'b1; wr_hash_adr_i[2] = 3'd6; wr_slot_i[2] = 2'b10;
    wr_key_i[2] = 4'hC; wr_data_i[2] = 8'hC3; wr_valid_i[2] = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    wr_en_i[2] = 1'b1; wr_slot_i[2] = 2'b01; wr_key_i[2] = 4'h5; wr_data_i[2] = 8'h5A;
    #2;
    check("reg_key",  100, 64'(forward_key_o[0][2]),  64'h0C);
    check("reg_data", 100, 64'(forward_data_o[0][2]), 64'hC3);
    check("reg_live", 100, 64'(live_stages_o),        64'd1);

    // Sticky error holds through a stall and clears only on reset
    idle_inputs();
    wr_en_i[1] = 1'b1; wr_slot_i[1] = 2'b11;
    @(posedge clk); #1;
    check("err_set", 101, 64'(slot_error_o), 64'd1);
    check("err_stage0", 101, 64'(forward_updated_mem_o[0][1]), 64'd0);
    idle_inputs(); clk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("err_stall", 102, 64'(slot_error_o), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("err_reset", 103, 64'(slot_error_o), 64'd0);
    check("live_reset", 103, 64'(live_stages_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
